// File: rtl/linescanner_pkg.sv
// Shared state encoding and default widths for the line-scan frame sequencer.
// The optional readout watchdog is enabled by LINESCANNER_LINE_TIMEOUT_EN.
package linescanner_pkg;

  localparam int unsigned LINE_CNT_W_DEF     = 12;
  localparam int unsigned PERIOD_W_DEF       = 16;
  localparam int unsigned PIX_CNT_W_DEF      = 12;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 4096;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LINE_RUN  = 2'd1,
    LINE_END  = 2'd2,
    FRAME_END = 2'd3
  } state_e;

endpackage

// File: rtl/linescanner_frame_sequencer_if.sv
// Host configuration / capture-unit signal bundle for the frame sequencer.
// err_timeout exists only when LINESCANNER_LINE_TIMEOUT_EN is defined.
interface linescanner_frame_sequencer_if
  import linescanner_pkg::*;
#(
  parameter int unsigned LINE_CNT_W = LINE_CNT_W_DEF,
  parameter int unsigned PERIOD_W   = PERIOD_W_DEF,
  parameter int unsigned PIX_CNT_W  = PIX_CNT_W_DEF
) ();

  logic                  start;
  logic                  stop;
  logic [LINE_CNT_W-1:0] cfg_lines;
  logic [PERIOD_W-1:0]   cfg_line_period;
  logic [PIX_CNT_W-1:0]  cfg_pixels;
  logic                  pixel_captured;
  logic                  capture_enable;
  logic                  busy;
  logic                  line_start;
  logic                  line_done;
  logic                  frame_done;
  logic [LINE_CNT_W-1:0] line_index;
  logic [PIX_CNT_W-1:0]  pixel_count;
  logic                  err_overrun;
  logic                  err_pixcount;
  logic                  aborted;
`ifdef LINESCANNER_LINE_TIMEOUT_EN
  logic                  err_timeout;
`endif

  // Host and capture unit side
  modport master (
    output start, stop, cfg_lines, cfg_line_period, cfg_pixels, pixel_captured,
    input  capture_enable, busy, line_start, line_done, frame_done,
    input  line_index, pixel_count, err_overrun, err_pixcount, aborted
`ifdef LINESCANNER_LINE_TIMEOUT_EN
    , input err_timeout
`endif
  );

  // Sequencer side
  modport slave (
    input  start, stop, cfg_lines, cfg_line_period, cfg_pixels, pixel_captured,
    output capture_enable, busy, line_start, line_done, frame_done,
    output line_index, pixel_count, err_overrun, err_pixcount, aborted
`ifdef LINESCANNER_LINE_TIMEOUT_EN
    , output err_timeout
`endif
  );

endinterface

// File: rtl/linescanner_line_timer.sv
// Per-line period counter with elapsed flag; optional readout watchdog
// under LINESCANNER_LINE_TIMEOUT_EN.
module linescanner_line_timer
  import linescanner_pkg::*;
#(
  parameter int unsigned PERIOD_W = PERIOD_W_DEF
`ifdef LINESCANNER_LINE_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
`endif
) (
  input  logic                pixel_clock,
  input  logic                n_reset,
  input  logic                run,
  input  logic [PERIOD_W-1:0] period,
  output logic                elapsed_c
`ifdef LINESCANNER_LINE_TIMEOUT_EN
  , output logic              timeout_c
`endif
);

  logic [PERIOD_W-1:0] period_eff_c;
  logic [PERIOD_W-1:0] period_cnt_q;

  // A programmed period of zero runs as a one-cycle period
  always_comb begin
    period_eff_c = period;
    if (period == '0) period_eff_c = PERIOD_W'(1);
  end

  assign elapsed_c = (period_cnt_q >= (period_eff_c - PERIOD_W'(1)));

  always_ff @(posedge pixel_clock or negedge n_reset) begin
    if (!n_reset) begin
      period_cnt_q <= '0;
    end else if (!run) begin
      period_cnt_q <= '0;
    end else if (period_cnt_q < period_eff_c) begin
      period_cnt_q <= period_cnt_q + PERIOD_W'(1);
    end
  end

`ifdef LINESCANNER_LINE_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_cnt_q;

  assign timeout_c = run && elapsed_c && (wd_cnt_q >= WD_LAST);

  // Counts only the overtime part of the line, after the period has elapsed
  always_ff @(posedge pixel_clock or negedge n_reset) begin
    if (!n_reset) begin
      wd_cnt_q <= '0;
    end else if (!run) begin
      wd_cnt_q <= '0;
    end else if (elapsed_c && (wd_cnt_q < WD_LAST)) begin
      wd_cnt_q <= wd_cnt_q + WD_W'(1);
    end
  end
`endif

endmodule

// File: rtl/linescanner_frame_sequencer.sv
// Frame-level controller for the line-scan capture unit: gates capture, times
// lines, counts pixels/lines. Watchdog option: LINESCANNER_LINE_TIMEOUT_EN.
module linescanner_frame_sequencer
  import linescanner_pkg::*;
#(
  parameter int unsigned LINE_CNT_W = LINE_CNT_W_DEF,
  parameter int unsigned PERIOD_W   = PERIOD_W_DEF,
  parameter int unsigned PIX_CNT_W  = PIX_CNT_W_DEF
`ifdef LINESCANNER_LINE_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
`endif
) (
  input  logic                          pixel_clock,
  input  logic                          n_reset,
  linescanner_frame_sequencer_if.slave  bus
);

  state_e state_q, state_d;

  logic [LINE_CNT_W-1:0] shadow_lines_q;
  logic [PERIOD_W-1:0]   shadow_period_q;
  logic [PIX_CNT_W-1:0]  shadow_pixels_q;
  logic [LINE_CNT_W-1:0] line_index_q;
  logic [PIX_CNT_W-1:0]  pixel_count_q;
  logic                  stop_pending_q;
  logic                  readout_seen_q;
  logic                  err_overrun_q, err_pixcount_q, aborted_q;

  logic capture_enable_q, busy_q, line_start_q, line_done_q, frame_done_q;
  logic capture_enable_d, busy_d, line_start_d, line_done_d, frame_done_d;

  logic run_c, elapsed_c, start_ok_c, line_end_c, last_line_c;

`ifdef LINESCANNER_LINE_TIMEOUT_EN
  logic timeout_c;
  logic err_timeout_q;
`endif

  assign run_c       = (state_q == LINE_RUN);
  assign start_ok_c  = bus.start && (bus.cfg_lines != '0);
  assign line_end_c  = elapsed_c && readout_seen_q && !bus.pixel_captured;
  assign last_line_c = (line_index_q == (shadow_lines_q - LINE_CNT_W'(1)));

  linescanner_line_timer #(
    .PERIOD_W       (PERIOD_W)
`ifdef LINESCANNER_LINE_TIMEOUT_EN
    , .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
`endif
  ) u_line_timer (
    .pixel_clock (pixel_clock),
    .n_reset     (n_reset),
    .run         (run_c),
    .period      (shadow_period_q),
    .elapsed_c   (elapsed_c)
`ifdef LINESCANNER_LINE_TIMEOUT_EN
    , .timeout_c (timeout_c)
`endif
  );

  // State register
  always_ff @(posedge pixel_clock or negedge n_reset) begin
    if (!n_reset) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (start_ok_c) state_d = LINE_RUN;
      LINE_RUN: begin
        if (line_end_c) state_d = LINE_END;
`ifdef LINESCANNER_LINE_TIMEOUT_EN
        else if (timeout_c) state_d = FRAME_END;
`endif
      end
      LINE_END:  state_d = (last_line_c || stop_pending_q) ? FRAME_END : LINE_RUN;
      FRAME_END: state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Output decode from the upcoming state, so registered outputs align with it
  always_comb begin
    capture_enable_d = (state_d == LINE_RUN) || (state_d == LINE_END);
    busy_d           = (state_d != IDLE);
    line_start_d     = (state_d == LINE_RUN) && (state_q != LINE_RUN);
    line_done_d      = (state_d == LINE_END);
    frame_done_d     = (state_d == FRAME_END);
`ifdef LINESCANNER_LINE_TIMEOUT_EN
    if ((state_q == LINE_RUN) && (state_d == FRAME_END)) line_done_d = 1'b1;
`endif
  end

  always_ff @(posedge pixel_clock or negedge n_reset) begin
    if (!n_reset) begin
      capture_enable_q <= 1'b0;
      busy_q           <= 1'b0;
      line_start_q     <= 1'b0;
      line_done_q      <= 1'b0;
      frame_done_q     <= 1'b0;
    end else begin
      capture_enable_q <= capture_enable_d;
      busy_q           <= busy_d;
      line_start_q     <= line_start_d;
      line_done_q      <= line_done_d;
      frame_done_q     <= frame_done_d;
    end
  end

  // Shadow config, counters and sticky status
  always_ff @(posedge pixel_clock or negedge n_reset) begin
    if (!n_reset) begin
      shadow_lines_q  <= '0;
      shadow_period_q <= '0;
      shadow_pixels_q <= '0;
      line_index_q    <= '0;
      pixel_count_q   <= '0;
      stop_pending_q  <= 1'b0;
      readout_seen_q  <= 1'b0;
      err_overrun_q   <= 1'b0;
      err_pixcount_q  <= 1'b0;
      aborted_q       <= 1'b0;
`ifdef LINESCANNER_LINE_TIMEOUT_EN
      err_timeout_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_ok_c) begin
            shadow_lines_q  <= bus.cfg_lines;
            shadow_period_q <= bus.cfg_line_period;
            shadow_pixels_q <= bus.cfg_pixels;
            line_index_q    <= '0;
            pixel_count_q   <= '0;
            stop_pending_q  <= 1'b0;
            readout_seen_q  <= 1'b0;
            err_overrun_q   <= 1'b0;
            err_pixcount_q  <= 1'b0;
            aborted_q       <= 1'b0;
`ifdef LINESCANNER_LINE_TIMEOUT_EN
            err_timeout_q   <= 1'b0;
`endif
          end
        end
        LINE_RUN: begin
          if (bus.pixel_captured) begin
            readout_seen_q <= 1'b1;
            if (pixel_count_q != '1) pixel_count_q <= pixel_count_q + PIX_CNT_W'(1);
          end
          if (elapsed_c && !line_end_c) err_overrun_q <= 1'b1;
          if (bus.stop) stop_pending_q <= 1'b1;
`ifdef LINESCANNER_LINE_TIMEOUT_EN
          if (timeout_c && !line_end_c) err_timeout_q <= 1'b1;
`endif
        end
        LINE_END: begin
          if (bus.stop) stop_pending_q <= 1'b1;
          if (pixel_count_q != shadow_pixels_q) err_pixcount_q <= 1'b1;
          if (state_d == LINE_RUN) begin
            line_index_q   <= line_index_q + LINE_CNT_W'(1);
            pixel_count_q  <= '0;
            readout_seen_q <= 1'b0;
          end
        end
        FRAME_END: begin
          if (stop_pending_q) aborted_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.capture_enable = capture_enable_q;
  assign bus.busy           = busy_q;
  assign bus.line_start     = line_start_q;
  assign bus.line_done      = line_done_q;
  assign bus.frame_done     = frame_done_q;
  assign bus.line_index     = line_index_q;
  assign bus.pixel_count    = pixel_count_q;
  assign bus.err_overrun    = err_overrun_q;
  assign bus.err_pixcount   = err_pixcount_q;
  assign bus.aborted        = aborted_q;
`ifdef LINESCANNER_LINE_TIMEOUT_EN
  assign bus.err_timeout    = err_timeout_q;
`endif

endmodule
